// File: rtl/gsim_out_collector.sv
// gsim_out_collector: captures 16-word Q16.16 solver frames into a ping-pong
// pair of banks, rounds each word to OUT_W bits and drains them over a
// valid/ready stream.
// Optional feature: define GSIM_OUT_SAT_EN to saturate converted words
// instead of wrapping them.
module gsim_out_collector #(
  parameter int FRAC_BITS = 16,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out_valid,
  input  logic [31:0]      x_out,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [OUT_W-1:0] y_data,
  output logic             y_last,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  typedef enum logic [1:0] {IDLE, CAPT, DROP} state_t;

  localparam logic signed [32:0] HALF = 33'sd1 <<< (FRAC_BITS - 1);

  state_t           state, state_n;
  logic [1:0]       full, full_n;
  logic             wp, wp_n, rp, rp_n;
  logic [3:0]       cnt, cnt_n, idx, idx_n;
  logic             quiet, quiet_n;
  logic             overrun_n, frame_err_n;
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic signed [32:0] sum, r;
  logic [OUT_W-1:0] conv;
  logic [OUT_W-1:0] mem [0:1][0:15];

  // Round half toward +inf in 33 bits, then saturate or wrap to OUT_W.
  always_comb begin
    sum = $signed({x_out[31], x_out}) + HALF;
    r   = sum >>> FRAC_BITS;
`ifdef GSIM_OUT_SAT_EN
    if (r > ((33'sd1 <<< (OUT_W - 1)) - 33'sd1))
      conv = {1'b0, {(OUT_W-1){1'b1}}};
    else if (r < -(33'sd1 <<< (OUT_W - 1)))
      conv = {1'b1, {(OUT_W-1){1'b0}}};
    else
      conv = r[OUT_W-1:0];
`else
    conv = r[OUT_W-1:0];
`endif
  end

`ifndef GSIM_OUT_SAT_EN
  logic unused_r;
  assign unused_r = ^r[32:OUT_W];
`endif

  // Drain side is purely a view of the rp bank; outputs are forced to zero
  // while nothing is presented so reset leaves y_data at 0.
  assign y_valid = full[rp];
  assign y_last  = y_valid & (idx == 4'd15);
  assign y_data  = y_valid ? mem[rp][idx] : '0;
  assign busy    = (state != IDLE) | full[0] | full[1];

  // Next-state logic for capture FSM, bank flags, pointers and sticky flags.
  // quiet marks "out_valid not yet seen low since reset": a frame already in
  // flight at release is dropped without flagging an overrun.
  always_comb begin
    state_n     = state;
    full_n      = full;
    wp_n        = wp;
    rp_n        = rp;
    cnt_n       = cnt;
    idx_n       = idx;
    quiet_n     = quiet;
    overrun_n   = overrun;
    frame_err_n = frame_err;
    wr_en       = 1'b0;
    wr_idx      = cnt;
    if (!out_valid) quiet_n = 1'b0;
    case (state)
      IDLE: begin
        if (out_valid) begin
          if (quiet || full[wp]) begin
            state_n = DROP;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            cnt_n   = 4'd1;
            state_n = CAPT;
          end
        end
      end
      CAPT: begin
        if (out_valid) begin
          wr_en  = 1'b1;
          wr_idx = cnt;
          cnt_n  = cnt + 4'd1;
          if (cnt == 4'd15) begin
            full_n[wp] = 1'b1;
            wp_n       = ~wp;
            cnt_n      = '0;
            state_n    = IDLE;
          end
        end else begin
          frame_err_n = 1'b1;
          cnt_n       = '0;
          state_n     = IDLE;
        end
      end
      DROP: begin
        if (!out_valid) begin
          if (!quiet) overrun_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Capture only ever completes into a non-full bank while the drain only
    // clears a full one, so both updates can land in the same cycle.
    if (y_valid && y_ready) begin
      idx_n = idx + 4'd1;
      if (idx == 4'd15) begin
        full_n[rp] = 1'b0;
        rp_n       = ~rp;
        idx_n      = '0;
      end
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      full      <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      quiet     <= 1'b1;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      full      <= full_n;
      wp        <= wp_n;
      rp        <= rp_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      quiet     <= quiet_n;
      overrun   <= overrun_n;
      frame_err <= frame_err_n;
    end
  end

  // Bank storage write port; contents are only meaningful while full is set.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp][wr_idx] <= conv;
  end

endmodule

// File: tb/tb_gsim_out_collector.sv
module tb_gsim_out_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_valid;
  logic [31:0] x_out;
  logic        y_valid;
  logic        y_ready;
  logic [15:0] y_data;
  logic        y_last;
  logic        busy;
  logic        overrun;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fw[16];

  gsim_out_collector #(.FRAC_BITS(16), .OUT_W(16)) dut (
    .clk(clk), .reset(rst_n), .out_valid(out_valid), .x_out(x_out),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference conversion: Q16.16 -> round half up -> 16 bits.
  function automatic logic [15:0] model(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + 64'sd32768) >>> 16;
`ifdef GSIM_OUT_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  task automatic push_exp(input logic [15:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive fw[0..n-1] on consecutive cycles, then drop out_valid.
  task automatic send_frame(input bit push, input int n);
    if (push) for (int i = 0; i < n; i++) push_exp(model(fw[i]), i == 15);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      out_valid = 1'b1;
      x_out     = fw[i];
    end
    @(negedge clk);
    out_valid = 1'b0;
    x_out     = '0;
  endtask

  // Accept n words with y_ready high, comparing each against the scoreboard.
  task automatic drain(input int n);
    int   got = 0;
    int   t = 0;
    exp_t e;
    y_ready = 1'b1;
    while (got < n && t < 400) begin
      if (y_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL drain_unexpected: got data %h last %b, expected no word", y_data, y_last);
        end else begin
          e = exp_q.pop_front();
          if (y_data !== e.d || y_last !== e.l) begin
            errors++;
            $display("FAIL drain_word %0d: got data %h last %b, expected data %h last %b",
                     got, y_data, y_last, e.d, e.l);
          end
        end
        got++;
      end
      @(negedge clk);
      t++;
    end
    y_ready = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words, expected %0d", got, n);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) fw[i] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_valid = 1'b0; x_out = '0; y_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_y_valid", 32'(y_valid), 0);
    chk("reset_y_last", 32'(y_last), 0);
    chk("reset_y_data", 32'(y_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 16; i++) fw[i] = 32'((i + 1) << 16);
    y_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_exp(16'(i + 1), i == 15);
    send_frame(1'b0, 16);
    chk("ramp_latency_y_valid", 32'(y_valid), 1);
    chk("ramp_busy", 32'(busy), 1);
    drain(16);
    chk("ramp_idle_y_valid", 32'(y_valid), 0);
    chk("ramp_idle_busy", 32'(busy), 0);
    chk("ramp_overrun", 32'(overrun), 0);
    chk("ramp_frame_err", 32'(frame_err), 0);
  endtask

  task automatic test_rounding();
    set_random();
    fw[0] = 32'h0001_8000; fw[1] = 32'hFFFE_8000; fw[2] = 32'h0000_7FFF;
    fw[3] = 32'h8000_0000; fw[4] = 32'h7FFF_FFFF;
    push_exp(16'd2, 1'b0);
    push_exp(16'hFFFF, 1'b0);
    push_exp(16'd0, 1'b0);
`ifdef GSIM_OUT_SAT_EN
    push_exp(16'h8000, 1'b0);
    push_exp(16'h7FFF, 1'b0);
`else
    push_exp(16'h8000, 1'b0);
    push_exp(16'h8000, 1'b0);
`endif
    for (int i = 5; i < 16; i++) push_exp(model(fw[i]), i == 15);
    send_frame(1'b0, 16);
    drain(16);
  endtask

  task automatic test_back_to_back();
    y_ready = 1'b0;
    set_random(); send_frame(1'b1, 16);
    set_random(); send_frame(1'b1, 16);
    set_random(); send_frame(1'b0, 16);
    @(negedge clk);
    chk("b2b_overrun", 32'(overrun), 1);
    chk("b2b_frame_err", 32'(frame_err), 0);
    for (int c = 0; c < 3; c++) begin
      chk("hold_y_valid", 32'(y_valid), 1);
      chk("hold_y_data", 32'(y_data), 32'(exp_q[0].d));
      chk("hold_y_last", 32'(y_last), 0);
      @(negedge clk);
    end
    drain(32);
    chk("b2b_empty_y_valid", 32'(y_valid), 0);
    chk("b2b_busy", 32'(busy), 0);
  endtask

  task automatic test_short_frame();
    set_random();
    send_frame(1'b0, 7);
    @(negedge clk);
    chk("short_frame_err", 32'(frame_err), 1);
    chk("short_y_valid", 32'(y_valid), 0);
    chk("short_busy", 32'(busy), 0);
    set_random();
    send_frame(1'b1, 16);
    drain(16);
  endtask

  task automatic test_simultaneous();
    y_ready = 1'b0;
    set_random();
    send_frame(1'b1, 16);
    set_random();
    fork
      send_frame(1'b1, 16);
      begin
        @(negedge clk);
        drain(16);
      end
    join
    drain(16);
    chk("simul_queue_empty", 32'(exp_q.size()), 0);
    chk("simul_busy", 32'(busy), 0);
  endtask

  task automatic test_reset_mid_drain();
    set_random();
    send_frame(1'b1, 16);
    drain(4);
    rst_n = 1'b0;
    #1;
    chk("rst_drain_y_valid", 32'(y_valid), 0);
    chk("rst_drain_busy", 32'(busy), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_random();
    send_frame(1'b1, 16);
    drain(16);
  endtask

  task automatic test_reset_mid_capture();
    set_random();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      out_valid = 1'b1;
      x_out     = fw[i];
      if (i == 5) rst_n = 1'b0;
      if (i == 7) rst_n = 1'b1;
    end
    @(negedge clk);
    out_valid = 1'b0;
    @(negedge clk);
    chk("rst_capt_y_valid", 32'(y_valid), 0);
    chk("rst_capt_overrun", 32'(overrun), 0);
    chk("rst_capt_busy", 32'(busy), 0);
    set_random();
    send_frame(1'b1, 16);
    drain(16);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rounding();
    test_back_to_back();
    test_short_frame();
    test_simultaneous();
    test_reset_mid_drain();
    test_reset_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
